// File: rtl/ysyx_issue_ctrl_if.sv
// Handshake bundle between IDU, the issue controller, the EXU and commit.
// slave is the issue controller's view; master is the surrounding pipeline's view.
interface ysyx_issue_ctrl_if #(
    parameter int RW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_rd;
    logic          in_wen;
    logic [RW-1:0] in_rs1;
    logic [RW-1:0] in_rs2;
    logic          in_rs1_use;
    logic          in_rs2_use;
    logic          in_system;
    logic          out_valid;
    logic          out_ready;
    logic          wb_valid;
    logic [RW-1:0] wb_rd;
    logic          flush;

    modport slave (
        input  in_valid, in_rd, in_wen, in_rs1, in_rs2, in_rs1_use, in_rs2_use,
               in_system, out_ready, wb_valid, wb_rd, flush,
        output in_ready, out_valid
    );

    modport master (
        output in_valid, in_rd, in_wen, in_rs1, in_rs2, in_rs1_use, in_rs2_use,
               in_system, out_ready, wb_valid, wb_rd, flush,
        input  in_ready, out_valid
    );
endinterface

// File: rtl/ysyx_issue_ctrl.sv
// In-order issue gate: register scoreboard, in-flight credits and a
// serialization FSM that drains the backend around system instructions.
module ysyx_issue_ctrl #(
    parameter int NR_REG       = 16,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    ysyx_issue_ctrl_if.slave    bus,
    output logic [31:0]         stall_cnt_o,
    output logic                protocol_err_o
);
    typedef enum logic {RUN, SERIAL} state_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_e              state_q, state_d;
    logic [NR_REG-1:0]   busy_q, busy_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic [31:0]         stall_q, stall_d;
    logic                err_q, err_d;

    logic hazard;
    logic ok;
    logic fire;
    logic wb;

    // Decisions look only at registered state; a write-back frees its
    // register for dependents one cycle later.
    always_comb begin
        hazard = 1'b0;
        if (bus.in_rs1_use && bus.in_rs1 != '0 && busy_q[bus.in_rs1]) hazard = 1'b1;
        if (bus.in_rs2_use && bus.in_rs2 != '0 && busy_q[bus.in_rs2]) hazard = 1'b1;
        if (bus.in_wen && bus.in_rd != '0 && busy_q[bus.in_rd])       hazard = 1'b1;
        ok = (state_q == RUN) && (inflight_q < MAX_CNT) && !hazard &&
             (!bus.in_system || inflight_q == '0);
    end

    assign bus.out_valid = bus.in_valid && ok && !bus.flush;
    assign bus.in_ready  = bus.out_ready && ok && !bus.flush;
    assign fire          = bus.in_valid && bus.in_ready;
    assign wb            = bus.wb_valid && !bus.flush;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        inflight_d = inflight_q;
        stall_d    = stall_q;
        err_d      = err_q;

        if (bus.in_valid && !fire && stall_q != '1) stall_d = stall_q + 32'd1;

        if (bus.flush) begin
            busy_d     = '0;
            inflight_d = '0;
            state_d    = RUN;
        end else begin
            // Clear before set so a same-cycle re-issue to the same rd stays busy.
            if (wb && bus.wb_rd != '0) busy_d[bus.wb_rd] = 1'b0;
            if (fire && bus.in_wen && bus.in_rd != '0) busy_d[bus.in_rd] = 1'b1;
            if (wb && inflight_q == '0) err_d = 1'b1;

            case ({fire, wb})
                2'b10:   inflight_d = inflight_q + ONE_CNT;
                2'b01:   if (inflight_q != '0) inflight_d = inflight_q - ONE_CNT;
                default: inflight_d = inflight_q;
            endcase

            case (state_q)
                RUN:     if (fire && bus.in_system) state_d = SERIAL;
                SERIAL:  if (wb && inflight_q == ONE_CNT) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            busy_q     <= '0;
            inflight_q <= '0;
            stall_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            stall_q    <= stall_d;
            err_q      <= err_d;
        end
    end

    assign stall_cnt_o    = stall_q;
    assign protocol_err_o = err_q;
endmodule

// File: tb/tb_ysyx_issue_ctrl.sv
// Directed vector bench for ysyx_issue_ctrl: each record is one cycle of
// inputs plus the expected handshake outputs and registered counters.
module tb_ysyx_issue_ctrl;
    typedef struct {
        logic        iv;
        logic [3:0]  rd;
        logic        wen;
        logic [3:0]  rs1;
        logic        r1u;
        logic [3:0]  rs2;
        logic        r2u;
        logic        sys;
        logic        ordy;
        logic        wbv;
        logic [3:0]  wbrd;
        logic        fl;
        logic        eov;
        logic        eir;
        logic [31:0] est;
        logic        eerr;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] stallCnt;
    logic        protocolErr;
    int          checkCount;
    int          passCount;
    vec_t        tbl[$];

    ysyx_issue_ctrl_if #(.RW(4)) bus ();

    ysyx_issue_ctrl #(
        .NR_REG(16),
        .MAX_INFLIGHT(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .stall_cnt_o(stallCnt),
        .protocol_err_o(protocolErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(int iv, int rd, int wen, int rs1, int r1u, int rs2, int r2u,
                                int sys, int ordy, int wbv, int wbrd, int fl,
                                int eov, int eir, int est, int eerr);
        vec_t v;
        v.iv   = (iv != 0);
        v.rd   = 4'(rd);
        v.wen  = (wen != 0);
        v.rs1  = 4'(rs1);
        v.r1u  = (r1u != 0);
        v.rs2  = 4'(rs2);
        v.r2u  = (r2u != 0);
        v.sys  = (sys != 0);
        v.ordy = (ordy != 0);
        v.wbv  = (wbv != 0);
        v.wbrd = 4'(wbrd);
        v.fl   = (fl != 0);
        v.eov  = (eov != 0);
        v.eir  = (eir != 0);
        v.est  = 32'(est);
        v.eerr = (eerr != 0);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.in_valid   = v.iv;
        bus.in_rd      = v.rd;
        bus.in_wen     = v.wen;
        bus.in_rs1     = v.rs1;
        bus.in_rs1_use = v.r1u;
        bus.in_rs2     = v.rs2;
        bus.in_rs2_use = v.r2u;
        bus.in_system  = v.sys;
        bus.out_ready  = v.ordy;
        bus.wb_valid   = v.wbv;
        bus.wb_rd      = v.wbrd;
        bus.flush      = v.fl;
    endtask

    task automatic checkOutput(input string name, input int idx, input vec_t v);
        checkCount++;
        if (bus.out_valid === v.eov) passCount++;
        else $display("[TB] FAIL %s[%0d] out_valid got %b want %b", name, idx, bus.out_valid, v.eov);
        checkCount++;
        if (bus.in_ready === v.eir) passCount++;
        else $display("[TB] FAIL %s[%0d] in_ready got %b want %b", name, idx, bus.in_ready, v.eir);
        checkCount++;
        if (stallCnt === v.est) passCount++;
        else $display("[TB] FAIL %s[%0d] stall_cnt got %0d want %0d", name, idx, stallCnt, v.est);
        checkCount++;
        if (protocolErr === v.eerr) passCount++;
        else $display("[TB] FAIL %s[%0d] protocol_err got %b want %b", name, idx, protocolErr, v.eerr);
    endtask

    task automatic applyStimulus(input string name, input int idx, input vec_t v);
        drive(v);
        #2;
        checkOutput(name, idx, v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        vec_t seq[$];
        checkCount = 0;
        passCount  = 0;
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
        rst_n = 1'b0;

        // independent stream, wb one cycle behind each issue
        tbl.push_back(mk(1,1,1,0,0,0,0,0,1,0,0,0,  1,1,0,0));
        tbl.push_back(mk(1,2,1,0,0,0,0,0,1,1,1,0,  1,1,0,0));
        tbl.push_back(mk(1,3,1,0,0,0,0,0,1,1,2,0,  1,1,0,0));
        tbl.push_back(mk(1,4,1,0,0,0,0,0,1,1,3,0,  1,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,4,0,  0,1,0,0));
        // RAW on r5 released at cycle 3
        tbl.push_back(mk(1,5,1,0,0,0,0,0,1,0,0,0,  1,1,0,0));
        tbl.push_back(mk(1,6,1,5,1,0,0,0,1,0,0,0,  0,0,0,0));
        tbl.push_back(mk(1,6,1,5,1,0,0,0,1,0,0,0,  0,0,1,0));
        tbl.push_back(mk(1,6,1,5,1,0,0,0,1,1,5,0,  0,0,2,0));
        tbl.push_back(mk(1,6,1,5,1,0,0,0,1,0,0,0,  1,1,3,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,6,0,  0,1,3,0));
        // credit exhaustion and release
        tbl.push_back(mk(1,7,1,0,0,0,0,0,1,0,0,0,  1,1,3,0));
        tbl.push_back(mk(1,8,1,0,0,0,0,0,1,0,0,0,  1,1,3,0));
        tbl.push_back(mk(1,9,1,0,0,0,0,0,1,0,0,0,  1,1,3,0));
        tbl.push_back(mk(1,10,1,0,0,0,0,0,1,0,0,0, 1,1,3,0));
        tbl.push_back(mk(1,11,1,0,0,0,0,0,1,0,0,0, 0,0,3,0));
        tbl.push_back(mk(1,11,1,0,0,0,0,0,1,1,7,0, 0,0,4,0));
        tbl.push_back(mk(1,11,1,0,0,0,0,0,1,0,0,0, 1,1,5,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,8,0,  0,0,5,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,9,0,  0,1,5,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,10,0, 0,1,5,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,11,0, 0,1,5,0));
        // EXU not ready
        tbl.push_back(mk(1,1,1,0,0,0,0,0,0,0,0,0,  1,0,5,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,0,0,  0,1,6,0));
        // WAW on r3
        tbl.push_back(mk(1,3,1,0,0,0,0,0,1,0,0,0,  1,1,6,0));
        tbl.push_back(mk(1,3,1,0,0,0,0,0,1,0,0,0,  0,0,6,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,3,0,  0,1,7,0));
        // x0 is never tracked
        tbl.push_back(mk(1,0,1,0,0,0,0,0,1,0,0,0,  1,1,7,0));
        tbl.push_back(mk(1,0,1,0,1,0,0,0,1,1,0,0,  1,1,7,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,0,0,  0,1,7,0));
        // RAW through rs2
        tbl.push_back(mk(1,9,1,0,0,0,0,0,1,0,0,0,  1,1,7,0));
        tbl.push_back(mk(1,10,1,0,0,9,1,0,1,0,0,0, 0,0,7,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,9,0,  0,1,8,0));

        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) applyStimulus("vec", i, tbl[i]);

        // serialization: system op waits for an empty backend, then blocks issue
        seq.delete();
        seq.push_back(mk(1,1,1,0,0,0,0,0,1,0,0,0,  1,1,8,0));
        seq.push_back(mk(1,2,1,0,0,0,0,0,1,0,0,0,  1,1,8,0));
        seq.push_back(mk(1,0,0,0,0,0,0,1,1,0,0,0,  0,0,8,0));
        seq.push_back(mk(1,0,0,0,0,0,0,1,1,1,1,0,  0,0,9,0));
        seq.push_back(mk(1,0,0,0,0,0,0,1,1,1,2,0,  0,0,10,0));
        seq.push_back(mk(1,0,0,0,0,0,0,1,1,0,0,0,  1,1,11,0));
        seq.push_back(mk(1,3,1,0,0,0,0,0,1,0,0,0,  0,0,11,0));
        seq.push_back(mk(1,3,1,0,0,0,0,0,1,1,0,0,  0,0,12,0));
        seq.push_back(mk(1,3,1,0,0,0,0,0,1,0,0,0,  1,1,13,0));
        seq.push_back(mk(0,0,0,0,0,0,0,0,1,1,3,0,  0,1,13,0));
        foreach (seq[i]) applyStimulus("serial", i, seq[i]);

        // flush with coincident wb, then spurious wb
        seq.delete();
        seq.push_back(mk(1,1,1,0,0,0,0,0,1,0,0,0,  1,1,13,0));
        seq.push_back(mk(1,2,1,0,0,0,0,0,1,0,0,0,  1,1,13,0));
        seq.push_back(mk(1,0,0,0,0,0,0,0,1,0,0,0,  1,1,13,0));
        seq.push_back(mk(1,4,1,1,1,0,0,0,1,1,2,1,  0,0,13,0));
        seq.push_back(mk(1,4,1,1,1,0,0,0,1,0,0,0,  1,1,14,0));
        seq.push_back(mk(1,5,1,0,0,0,0,0,1,0,0,1,  0,0,14,0));
        seq.push_back(mk(0,0,0,0,0,0,0,0,1,1,0,1,  0,0,15,0));
        seq.push_back(mk(0,0,0,0,0,0,0,0,1,1,0,0,  0,1,15,0));
        seq.push_back(mk(1,5,1,0,0,0,0,0,1,0,0,0,  1,1,15,1));
        seq.push_back(mk(0,0,0,0,0,0,0,0,1,1,5,0,  0,1,15,1));
        seq.push_back(mk(1,6,1,0,0,0,0,0,1,0,0,0,  1,1,15,1));
        foreach (seq[i]) applyStimulus("flush", i, seq[i]);

        // async reset mid-operation clears r6 and counters immediately
        v = mk(1,7,1,6,1,0,0,0,1,0,0,0, 0,0,15,1);
        drive(v);
        #2;
        checkOutput("prerst", 0, v);
        rst_n = 1'b0;
        #1;
        v = mk(1,7,1,6,1,0,0,0,1,0,0,0, 1,1,0,0);
        checkOutput("inrst", 0, v);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("postrst", 0, mk(1,8,1,6,1,0,0,0,1,0,0,0, 1,1,0,0));
        applyStimulus("postrst", 1, mk(1,9,1,7,1,0,0,0,1,0,0,0, 0,0,0,0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/ysyx_issue_ctrl.md
# ysyx_issue_ctrl

In-order issue controller between the decode stage (IDU) and the execute/LSU backend. It gates the IDU→EXU pipe handshake using a register scoreboard, an in-flight credit counter and a serialization FSM. System instructions (CSR, ecall, ebreak, mret) issue only into an empty backend and block all later issue until they complete. Flush from the commit stage discards all in-flight tracking.

## Interface

Parameters:
- `NR_REG`, 16: architectural registers; RV32E, 4-bit specifiers; x0 is never tracked.
- `MAX_INFLIGHT`, 4: maximum issued-but-not-written-back ops.
- `CNT_W`, 3: in-flight counter width; must hold `MAX_INFLIGHT`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  IDU holds a decoded op.
- `in_ready`  out  1  op accepted this cycle.
- `in_rd`  in  4  destination register.
- `in_wen`  in  1  op writes `in_rd`.
- `in_rs1`, `in_rs2`  in  4 each  source registers.
- `in_rs1_use`, `in_rs2_use`  in  1 each  source is read.
- `in_system`  in  1  serializing op (OR of system, csr_wen, ecall, ebreak, mret).
- `out_valid`  out  1  op presented to EXU.
- `out_ready`  in  1  EXU accepts.
- `wb_valid`  in  1  one issued op completed; exactly one pulse per issued op, including ops with no write.
- `wb_rd`  in  4  register released; 0 if no write.
- `flush`  in  1  commit-stage redirect; all remaining in-flight ops are squashed.
- `stall_cnt`  out  32  cycles with `in_valid` and no fire.
- `protocol_err`  out  1  sticky; set on `wb_valid` with zero in-flight ops.

## Operation

- State: `busy[NR_REG-1:1]`, `inflight[CNT_W-1:0]`, FSM {RUN, SERIAL}, `stall_cnt`, `protocol_err`.
- All issue checks use registered state only. There is no same-cycle write-back bypass.
- `ok` = state==RUN & inflight<MAX_INFLIGHT & no hazard & (!in_system | inflight==0).
  - Hazard = (in_rs1_use & rs1≠0 & busy[rs1]) | (in_rs2_use & rs2≠0 & busy[rs2]) | (in_wen & rd≠0 & busy[rd]).
  - The rd (WAW) term guarantees a single outstanding writer per register.
- Outputs:
  - `out_valid` = in_valid & ok & !flush.
  - `in_ready` = out_ready & ok & !flush.
  - fire = in_valid & in_ready.
- On fire:
  - Set busy[in_rd] if in_wen & rd≠0.
  - inflight+1.
  - If in_system, go RUN→SERIAL.
- On wb_valid (no flush):
  - Clear busy[wb_rd] if wb_rd≠0.
  - inflight−1. If inflight==0, leave inflight at 0 and set protocol_err.
- Fire and wb in the same cycle:
  - inflight unchanged.
  - If in_rd==wb_rd, busy ends set (the new writer wins).
- SERIAL→RUN when inflight==1 and wb_valid (the system op completes). No issue while in SERIAL.
- flush has highest priority:
  - Clears all busy bits and sets inflight=0 and state=RUN.
  - Forces out_valid=0 and in_ready=0 that cycle.
  - wb_valid in the same cycle is ignored.
  - stall_cnt still increments if in_valid.
- stall_cnt saturates at 2^32−1.
- Reset values: busy=0, inflight=0, state=RUN, stall_cnt=0, protocol_err=0. Consequently out_valid=in_valid & !flush and in_ready=out_ready & !flush, both subject to hazard checks, which are clear at reset.

## Timing

- `out_valid` and `in_ready` are combinational from inputs and registered state; zero-latency pass-through when `ok`.
- A register released by wb in cycle N becomes issuable for dependents at cycle N+1. A RAW dependent back-to-back on a 1-cycle EXU therefore sees 1 bubble.
- Credit freed by wb in cycle N is usable at N+1.
- A system op issued at cycle N lets the next op issue no earlier than the cycle after its wb.
- Async reset asserts mid-operation: all state clears immediately. The backend is reset concurrently.

## Test plan

- Reset then independent ALU stream: `in_valid`=1, `out_ready`=1, rd=1..4 with no source overlap and a wb 1 cycle after each fire → fires every cycle, `stall_cnt`=0, inflight never exceeds 2.
- RAW: issue rd=5, then an op with rs1=5 (`in_rs1_use`=1); wb_rd=5 at cycle 3 → second op is blocked in cycles 1–3, fires at cycle 4, `stall_cnt`=3.
- Credit full: 4 ops issue with no wb → 5th blocked (`in_ready`=0). A single wb at cycle N → 5th fires at N+1.
- Serialization: 2 ops in flight, then `in_system`=1 → blocked until both wb. The system op fires, then the next op is held until the system wb, then fires the following cycle.
- Flush mid-flight: 3 ops outstanding (busy r1,r2), `flush`=1 coincident with a wb → busy=0 and inflight=0 next cycle, and a dependent on r1 fires immediately after.
- Spurious wb with inflight=0 → `protocol_err`=1 and stays set; inflight remains 0.
